// File: rtl/se_ctx_loader_pkg.sv
// Shared widths, packet beat indices and FSM encodings
// for the SE context loader.
package se_ctx_loader_pkg;

    localparam int DATA_W = 16;
    localparam int SW_W   = 4;
    localparam int CONF_W = 4 * SW_W;
    localparam int N_CTX  = 4;
    localparam int CTX_W  = 2;

    localparam logic [1:0] BEAT_W0 = 2'd0;
    localparam logic [1:0] BEAT_W1 = 2'd1;
    localparam logic [1:0] BEAT_W2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = BEAT_W0,
        ST_W1     = BEAT_W1,
        ST_W2     = BEAT_W2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/se_ctx_store.sv
// N_CTX-entry context register file, one write and one read port,
// with write data bypassed onto a same-cycle read of that entry.
module se_ctx_store #(
    parameter int N_CTX   = 4,
    parameter int CTX_W   = 2,
    parameter int ENTRY_W = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [CTX_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [CTX_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [N_CTX];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CTX; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/se_ctx_loader.sv
// Config-bus packet loader feeding the switch element with the
// routing word and constants of the active context.
module se_ctx_loader #(
    parameter int DATA_W = se_ctx_loader_pkg::DATA_W,
    parameter int SW_W   = se_ctx_loader_pkg::SW_W,
    parameter int N_CTX  = se_ctx_loader_pkg::N_CTX,
    parameter int CTX_W  = se_ctx_loader_pkg::CTX_W,
    parameter int ID_W   = 6,
    parameter int PE_ID  = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [ID_W-1:0]   CFG_ID,
    input  logic [CTX_W-1:0]  CFG_CTX,
    input  logic              CFG_LAST,
    input  logic [DATA_W-1:0] CFG_DATA,
    input  logic              CTX_SWITCH,
    input  logic [CTX_W-1:0]  CTX_SEL,
    output logic [4*SW_W-1:0] CONF_SE,
    output logic [DATA_W-1:0] CONST_A,
    output logic [DATA_W-1:0] CONST_B,
    output logic [CTX_W-1:0]  ACT_CTX,
    output logic              BUSY,
    output logic              ERR
);

    import se_ctx_loader_pkg::*;

    localparam int CW      = 4 * SW_W;
    localparam int ENTRY_W = CW + 2 * DATA_W;

    state_t state, state_nx;

    logic [CW-1:0]     stg_conf;
    logic [DATA_W-1:0] stg_a;
    logic [DATA_W-1:0] stg_b;
    logic [CTX_W-1:0]  tgt_ctx;

    logic ready_q, busy_q, err_q;
    logic hit;
    logic ld_w0, ld_a, ld_b, set_err, commit;

    logic [CTX_W-1:0]   act_q, next_act;
    logic [ENTRY_W-1:0] rd_entry;
    logic [CW-1:0]      conf_q;
    logic [DATA_W-1:0]  a_q, b_q;

    assign hit = CFG_VALID && ready_q
              && (CFG_ID == ID_W'(PE_ID));

    always_comb begin
        state_nx = state;
        ld_w0    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        set_err  = 1'b0;
        commit   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    ld_w0 = 1'b1;
                    if (CFG_LAST) set_err  = 1'b1;
                    else          state_nx = ST_W1;
                end
            end
            ST_W1: begin
                if (hit) begin
                    ld_a = 1'b1;
                    if (CFG_LAST) begin
                        set_err  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_W2;
                    end
                end
            end
            ST_W2: begin
                if (hit) begin
                    ld_b = 1'b1;
                    if (!CFG_LAST) begin
                        set_err  = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                commit   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // READY and BUSY are registered from the next state so
    // every output comes straight off a flop.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            stg_conf <= '0;
            stg_a    <= '0;
            stg_b    <= '0;
            tgt_ctx  <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != ST_COMMIT);
            busy_q  <= (state_nx != ST_IDLE);
            if (set_err) err_q <= 1'b1;
            if (ld_w0) begin
                stg_conf <= CFG_DATA[CW-1:0];
                tgt_ctx  <= CFG_CTX;
            end
            if (ld_a) stg_a <= CFG_DATA;
            if (ld_b) stg_b <= CFG_DATA;
        end
    end

    assign next_act = CTX_SWITCH ? CTX_SEL : act_q;

    se_ctx_store #(
        .N_CTX   (N_CTX),
        .CTX_W   (CTX_W),
        .ENTRY_W (ENTRY_W)
    ) u_store (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (commit),
        .waddr (tgt_ctx),
        .wdata ({stg_conf, stg_a, stg_b}),
        .raddr (next_act),
        .rdata (rd_entry)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            act_q  <= '0;
            conf_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            act_q  <= next_act;
            conf_q <= rd_entry[ENTRY_W-1 -: CW];
            a_q    <= rd_entry[2*DATA_W-1 -: DATA_W];
            b_q    <= rd_entry[DATA_W-1:0];
        end
    end

    assign CFG_READY = ready_q;
    assign BUSY      = busy_q;
    assign ERR       = err_q;
    assign ACT_CTX   = act_q;
    assign CONF_SE   = conf_q;
    assign CONST_A   = a_q;
    assign CONST_B   = b_q;

endmodule

// File: tb/tb_se_ctx_loader.sv
// Directed self-checking bench for se_ctx_loader.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_se_ctx_loader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [5:0]  CFG_ID;
    logic [1:0]  CFG_CTX;
    logic        CFG_LAST;
    logic [15:0] CFG_DATA;
    logic        CTX_SWITCH;
    logic [1:0]  CTX_SEL;
    logic [15:0] CONF_SE;
    logic [15:0] CONST_A;
    logic [15:0] CONST_B;
    logic [1:0]  ACT_CTX;
    logic        BUSY;
    logic        ERR;

    int checks   = 0;
    int failures = 0;

    se_ctx_loader #(
        .DATA_W (16),
        .SW_W   (4),
        .N_CTX  (4),
        .CTX_W  (2),
        .ID_W   (6),
        .PE_ID  (0)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .CFG_ID     (CFG_ID),
        .CFG_CTX    (CFG_CTX),
        .CFG_LAST   (CFG_LAST),
        .CFG_DATA   (CFG_DATA),
        .CTX_SWITCH (CTX_SWITCH),
        .CTX_SEL    (CTX_SEL),
        .CONF_SE    (CONF_SE),
        .CONST_A    (CONST_A),
        .CONST_B    (CONST_B),
        .ACT_CTX    (ACT_CTX),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [5:0]  id,
                        input logic [1:0]  ctx,
                        input logic        last,
                        input logic [15:0] data);
        int n;
        CFG_VALID = 1'b1;
        CFG_ID    = id;
        CFG_CTX   = ctx;
        CFG_LAST  = last;
        CFG_DATA  = data;
        n = 0;
        while (!CFG_READY && n < 8) begin
            tick();
            n++;
        end
        if (n == 8) check("ready_timeout", 64'(CFG_READY), 64'd1);
        tick();
        CFG_VALID = 1'b0;
        CFG_LAST  = 1'b0;
    endtask

    task automatic switch_to(input logic [1:0] c);
        CTX_SWITCH = 1'b1;
        CTX_SEL    = c;
        tick();
        CTX_SWITCH = 1'b0;
    endtask

    task automatic check_out(input string tag,
                             input logic [15:0] conf,
                             input logic [15:0] a,
                             input logic [15:0] b);
        check({tag, "_conf"}, 64'(CONF_SE), 64'(conf));
        check({tag, "_a"},    64'(CONST_A), 64'(a));
        check({tag, "_b"},    64'(CONST_B), 64'(b));
    endtask

    initial begin
        RST_N      = 1'b0;
        CFG_VALID  = 1'b0;
        CFG_ID     = '0;
        CFG_CTX    = '0;
        CFG_LAST   = 1'b0;
        CFG_DATA   = '0;
        CTX_SWITCH = 1'b0;
        CTX_SEL    = '0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        check_out("rst", 16'h0, 16'h0, 16'h0);
        check("rst_act",   64'(ACT_CTX),   64'd0);
        check("rst_ready", 64'(CFG_READY), 64'd1);
        check("rst_busy",  64'(BUSY),      64'd0);
        check("rst_err",   64'(ERR),       64'd0);

        beat(6'd0, 2'd0, 1'b0, 16'h1234);
        beat(6'd0, 2'd0, 1'b0, 16'h00AA);
        check("ld0_busy", 64'(BUSY), 64'd1);
        beat(6'd0, 2'd0, 1'b1, 16'h00BB);
        check("ld0_commit_ready", 64'(CFG_READY), 64'd0);
        check("ld0_pre_conf", 64'(CONF_SE), 64'h0);
        tick();
        check("ld0_post_ready", 64'(CFG_READY), 64'd1);
        check("ld0_post_busy",  64'(BUSY),      64'd0);
        check_out("ld0", 16'h1234, 16'h00AA, 16'h00BB);

        beat(6'd0, 2'd2, 1'b0, 16'h4321);
        beat(6'd0, 2'd0, 1'b0, 16'h0011);
        beat(6'd0, 2'd0, 1'b1, 16'h0022);
        tick();
        check_out("ld2_inactive", 16'h1234, 16'h00AA, 16'h00BB);
        switch_to(2'd2);
        check("sw2_act", 64'(ACT_CTX), 64'd2);
        check_out("sw2", 16'h4321, 16'h0011, 16'h0022);

        beat(6'd0, 2'd3, 1'b0, 16'h0F0F);
        beat(6'd1, 2'd0, 1'b1, 16'hDEAD);
        beat(6'd0, 2'd1, 1'b0, 16'h0033);
        beat(6'd1, 2'd2, 1'b0, 16'hBEEF);
        beat(6'd0, 2'd1, 1'b1, 16'h0044);
        tick();
        check("fgn_err", 64'(ERR), 64'd0);
        check_out("fgn_still2", 16'h4321, 16'h0011, 16'h0022);
        switch_to(2'd3);
        check_out("fgn_ctx3", 16'h0F0F, 16'h0033, 16'h0044);

        beat(6'd0, 2'd3, 1'b0, 16'h1111);
        beat(6'd0, 2'd3, 1'b1, 16'h2222);
        check("early_err",   64'(ERR),       64'd1);
        check("early_busy",  64'(BUSY),      64'd0);
        check("early_ready", 64'(CFG_READY), 64'd1);
        tick();
        check_out("early_store", 16'h0F0F, 16'h0033, 16'h0044);

        beat(6'd0, 2'd3, 1'b0, 16'h5555);
        beat(6'd0, 2'd3, 1'b0, 16'h6666);
        beat(6'd0, 2'd3, 1'b0, 16'h7777);
        check("nolast_busy", 64'(BUSY), 64'd0);
        tick();
        check_out("nolast_store", 16'h0F0F, 16'h0033, 16'h0044);

        beat(6'd0, 2'd3, 1'b0, 16'h00C3);
        beat(6'd0, 2'd3, 1'b0, 16'h000C);
        beat(6'd0, 2'd3, 1'b1, 16'h000D);
        tick();
        check_out("good_after_err", 16'h00C3, 16'h000C, 16'h000D);
        check("err_sticky", 64'(ERR), 64'd1);

        beat(6'd0, 2'd1, 1'b0, 16'hABCD);
        beat(6'd0, 2'd1, 1'b0, 16'h0101);
        beat(6'd0, 2'd1, 1'b1, 16'h0202);
        switch_to(2'd1);
        check("sim_act", 64'(ACT_CTX), 64'd1);
        check_out("sim_bypass", 16'hABCD, 16'h0101, 16'h0202);
        switch_to(2'd0);
        check_out("sim_ctx0", 16'h1234, 16'h00AA, 16'h00BB);

        beat(6'd0, 2'd0, 1'b0, 16'h9999);
        beat(6'd0, 2'd0, 1'b0, 16'h8888);
        check("mid_busy", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
        check_out("mid_rst", 16'h0, 16'h0, 16'h0);
        check("mid_busy0", 64'(BUSY),      64'd0);
        check("mid_err0",  64'(ERR),       64'd0);
        check("mid_ready", 64'(CFG_READY), 64'd1);
        check("mid_act",   64'(ACT_CTX),   64'd0);
        switch_to(2'd2);
        check_out("mid_ctx2_zero", 16'h0, 16'h0, 16'h0);
        tick();
        check_out("mid_no_partial", 16'h0, 16'h0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
